// File: rtl/ethernet_mmio_arbiter.sv
// rtl/ethernet_mmio_arbiter.sv - two-requester round-robin MMIO arbiter with in-order response ID FIFO
// Optional accept counters enabled by `define ETH_MMIO_ARB_PERF_EN.
module ethernet_mmio_arbiter #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 14,
  parameter int size_width_p = 2,
  parameter int els_p        = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
`ifdef ETH_MMIO_ARB_PERF_EN
  input  logic                      perf_clear_i,
  output logic [31:0]               perf_grant_o,
`endif
  input  logic [1:0]                req_v_i,
  input  logic [1:0]                req_w_i,
  input  logic [2*addr_width_p-1:0] req_addr_i,
  input  logic [2*size_width_p-1:0] req_size_i,
  input  logic [2*data_width_p-1:0] req_data_i,
  output logic [1:0]                req_ready_and_o,
  output logic [1:0]                resp_v_o,
  output logic [data_width_p-1:0]   resp_data_o,
  output logic                      resp_err_o,
  input  logic [1:0]                resp_ready_and_i,
  output logic [addr_width_p-1:0]   mm_addr_o,
  output logic                      mm_write_en_o,
  output logic                      mm_read_en_o,
  output logic [size_width_p-1:0]   mm_op_size_o,
  output logic [data_width_p-1:0]   mm_write_data_o,
  input  logic                      mm_ready_and_i,
  input  logic                      mm_decode_error_i,
  input  logic                      mm_valid_i,
  input  logic [data_width_p-1:0]   mm_read_data_i,
  output logic                      mm_ready_and_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic                last_grant_q, last_grant_d;
  logic [els_p-1:0]    fifo_id_q, fifo_id_d;
  logic [els_p-1:0]    fifo_err_q, fifo_err_d;
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;

  logic grant_v, grant_id, nonempty, hid, herr, can_push, push, pop;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // Pop is resolved before push so a full FIFO can accept into the slot being freed.
  always_comb begin
    grant_v        = |req_v_i;
    grant_id       = (req_v_i == 2'b11) ? ~last_grant_q : req_v_i[1];
    nonempty       = (count_q != '0);
    hid            = fifo_id_q[rptr_q];
    herr           = fifo_err_q[rptr_q];
    mm_ready_and_o = nonempty & resp_ready_and_i[hid];
    pop            = mm_valid_i & mm_ready_and_o;
    can_push       = (count_q < cnt_w_lp'(els_p)) | pop;
    push           = grant_v & can_push & mm_ready_and_i;
  end

  always_comb begin
    mm_addr_o       = grant_id ? req_addr_i[addr_width_p +: addr_width_p] : req_addr_i[0 +: addr_width_p];
    mm_op_size_o    = grant_id ? req_size_i[size_width_p +: size_width_p] : req_size_i[0 +: size_width_p];
    mm_write_data_o = grant_id ? req_data_i[data_width_p +: data_width_p] : req_data_i[0 +: data_width_p];
    mm_write_en_o   = grant_v & can_push & req_w_i[grant_id];
    mm_read_en_o    = grant_v & can_push & ~req_w_i[grant_id];
    req_ready_and_o = '0;
    if (push) req_ready_and_o[grant_id] = 1'b1;
    resp_v_o        = '0;
    if (nonempty) resp_v_o[hid] = mm_valid_i;
    resp_data_o     = mm_read_data_i;
    resp_err_o      = herr;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    fifo_id_d    = fifo_id_q;
    fifo_err_d   = fifo_err_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    if (push) begin
      fifo_id_d[wptr_q]  = grant_id;
      fifo_err_d[wptr_q] = mm_decode_error_i;
      wptr_d             = ptr_inc(wptr_q);
      last_grant_d       = grant_id;
    end
    if (pop) rptr_d = ptr_inc(rptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_grant_q <= 1'b1;
      fifo_id_q    <= '0;
      fifo_err_q   <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      fifo_id_q    <= fifo_id_d;
      fifo_err_q   <= fifo_err_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
    end
  end

`ifdef ETH_MMIO_ARB_PERF_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (perf_clear_i) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (push) begin
      if (grant_id) begin
        if (cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
      end else begin
        if (cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign perf_grant_o = {cnt1_q, cnt0_q};
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding means the memory map broke the one-response-per-accept contract.
  assert property (@(posedge clk_i) disable iff (reset_i) !(mm_valid_i && !nonempty))
    else $error("ethernet_mmio_arbiter: mm_valid_i with no outstanding request");
`endif

endmodule
